// File: rtl/stat_ram_ctrl.sv
// ----------------------------------------------------------------------------
// stat_ram_ctrl
//
// Read-modify-write sequencer for port A of the MAC statistics dual-port RAM.
// Zero-fills the RAM after reset. Serves host CPU counter reads at top
// priority. Round-robins saturating increment events between RX and TX.
//
// Parameters
//   DATA_WIDTH  counter width, equal to the RAM data width
//   ADDR_WIDTH  counter index width; RAM depth is 2**ADDR_WIDTH
//
// Ports
//   Clk, Reset            clock; synchronous active-high reset
//   Rx_inc_req/addr/gnt   RX increment request, counter index, grant
//   Tx_inc_req/addr/gnt   TX increment request, counter index, grant
//   Cpu_rd_req/addr       CPU read request (held until ack), counter index
//   Cpu_rd_ack/data       one-cycle ack with the counter value
//   Init_busy             high while the RAM is being zero-filled
//   ram_addr/wdata/wren   to RAM port A (address_a, data_a, wren_a)
//   ram_rdata             from RAM port A (q_a), zero read latency
//
// Configuration
//   STAT_CLEAR_ON_READ_EN  when defined, a CPU read clears the counter.
//                          The read then takes 3 cycles instead of 2.
// ----------------------------------------------------------------------------
module stat_ram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Rx_inc_req,
    input  logic [ADDR_WIDTH-1:0] Rx_inc_addr,
    output logic                  Rx_inc_gnt,
    input  logic                  Tx_inc_req,
    input  logic [ADDR_WIDTH-1:0] Tx_inc_addr,
    output logic                  Tx_inc_gnt,
    input  logic                  Cpu_rd_req,
    input  logic [ADDR_WIDTH-1:0] Cpu_rd_addr,
    output logic                  Cpu_rd_ack,
    output logic [DATA_WIDTH-1:0] Cpu_rd_data,
    output logic                  Init_busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        INC_RD,
        INC_WR,
`ifdef STAT_CLEAR_ON_READ_EN
        CPU_CLR,
`endif
        CPU_RD
    } state_t;

    typedef enum logic {
        SRC_RX,
        SRC_TX
    } src_t;

    state_t                state;
    src_t                  last_rr;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] inc_val;
    logic                  idle_ok;
    logic                  cpu_sel;
    logic                  rx_sel;
    logic                  tx_sel;

    // Arbitration. The CPU request is still high during its own ack cycle,
    // so it is ignored while Cpu_rd_ack is set to avoid a duplicate read.
    assign idle_ok = (state == IDLE) && !Reset;
    assign cpu_sel = idle_ok && Cpu_rd_req && !Cpu_rd_ack;
    assign rx_sel  = idle_ok && !cpu_sel && Rx_inc_req &&
                     (!Tx_inc_req || last_rr == SRC_TX);
    assign tx_sel  = idle_ok && !cpu_sel && Tx_inc_req &&
                     (!Rx_inc_req || last_rr == SRC_RX);

    assign Rx_inc_gnt = rx_sel;
    assign Tx_inc_gnt = tx_sel;
    assign Init_busy  = Reset || (state == INIT);

    // Saturating increment: an all-ones counter stays all-ones.
    assign inc_val = (&rd_q) ? rd_q : rd_q + DATA_WIDTH'(1);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= INIT;
            init_cnt    <= '0;
            last_rr     <= SRC_TX;
            Cpu_rd_ack  <= 1'b0;
            Cpu_rd_data <= '0;
        end else begin
            Cpu_rd_ack <= 1'b0;
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (init_cnt == {ADDR_WIDTH{1'b1}}) state <= IDLE;
                end
                IDLE: begin
                    if (cpu_sel) begin
                        state <= CPU_RD;
                    end else if (rx_sel) begin
                        state <= INC_RD;
                        if (Tx_inc_req) last_rr <= SRC_RX;
                    end else if (tx_sel) begin
                        state <= INC_RD;
                        if (Rx_inc_req) last_rr <= SRC_TX;
                    end
                end
                INC_RD: state <= INC_WR;
                INC_WR: state <= IDLE;
                CPU_RD: begin
                    Cpu_rd_data <= ram_rdata;
                    Cpu_rd_ack  <= 1'b1;
`ifdef STAT_CLEAR_ON_READ_EN
                    state       <= CPU_CLR;
`else
                    state       <= IDLE;
`endif
                end
`ifdef STAT_CLEAR_ON_READ_EN
                CPU_CLR: state <= IDLE;
`endif
                default: state <= INIT;
            endcase
        end
    end

    // NOTE: pure datapath registers carry no reset; every consumer only
    // looks at them after they have been loaded by an accepted request.
    always_ff @(posedge Clk) begin
        if (cpu_sel) begin
            op_addr <= Cpu_rd_addr;
        end else if (rx_sel) begin
            op_addr <= Rx_inc_addr;
        end else if (tx_sel) begin
            op_addr <= Tx_inc_addr;
        end
        if (state == INC_RD) rd_q <= ram_rdata;
    end

    // RAM port A drive. Reset forces the write enable low in every state.
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        ram_addr  = (state == INIT) ? init_cnt : op_addr;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        case (state)
            INIT:    ram_wren = !Reset;
            INC_WR: begin
                ram_wdata = inc_val;
                ram_wren  = !Reset;
            end
`ifdef STAT_CLEAR_ON_READ_EN
            CPU_CLR: ram_wren = !Reset;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stat_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stat_ram_ctrl
//
// Self-checking bench for stat_ram_ctrl (DATA_WIDTH=32, ADDR_WIDTH=4).
// Provides a zero-latency RAM behind port A. Keeps an array of expected
// counter values that is updated on every accepted event.
// ----------------------------------------------------------------------------
module tb_stat_ram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Rx_inc_req = 1'b0;
    logic [AW-1:0] Rx_inc_addr = '0;
    logic          Rx_inc_gnt;
    logic          Tx_inc_req = 1'b0;
    logic [AW-1:0] Tx_inc_addr = '0;
    logic          Tx_inc_gnt;
    logic          Cpu_rd_req = 1'b0;
    logic [AW-1:0] Cpu_rd_addr = '0;
    logic          Cpu_rd_ack;
    logic [DW-1:0] Cpu_rd_data;
    logic          Init_busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;
    logic [DW-1:0] ram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Zero-latency RAM, plus a side port that lets the bench preload a word.
    logic [DW-1:0] mem [DEPTH];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    // Reference model: expected counter values and last contention winner.
    logic [DW-1:0] exp_cnt [DEPTH];
    bit            model_last_tx = 1'b1;

    always #5 Clk = ~Clk;

    assign ram_rdata = mem[ram_addr];

    always @(posedge Clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    stat_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Rx_inc_req (Rx_inc_req),
        .Rx_inc_addr(Rx_inc_addr),
        .Rx_inc_gnt (Rx_inc_gnt),
        .Tx_inc_req (Tx_inc_req),
        .Tx_inc_addr(Tx_inc_addr),
        .Tx_inc_gnt (Tx_inc_gnt),
        .Cpu_rd_req (Cpu_rd_req),
        .Cpu_rd_addr(Cpu_rd_addr),
        .Cpu_rd_ack (Cpu_rd_ack),
        .Cpu_rd_data(Cpu_rd_data),
        .Init_busy  (Init_busy),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .ram_rdata  (ram_rdata)
    );

    // ---------------- reference model ----------------
    function automatic void model_inc(input logic [AW-1:0] a);
        if (exp_cnt[a] != {DW{1'b1}}) exp_cnt[a] = exp_cnt[a] + 1;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        model_read = exp_cnt[a];
`ifdef STAT_CLEAR_ON_READ_EN
        exp_cnt[a] = '0;
`endif
    endfunction

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // one more unit later, well clear of the next edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_inc(input bit is_tx, input logic [AW-1:0] a);
        bit got = 1'b0;
        if (is_tx) begin Tx_inc_req = 1'b1; Tx_inc_addr = a; end
        else       begin Rx_inc_req = 1'b1; Rx_inc_addr = a; end
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if ((is_tx ? Tx_inc_gnt : Rx_inc_gnt) === 1'b1) got = 1'b1;
            tick();
        end
        Tx_inc_req = 1'b0;
        Rx_inc_req = 1'b0;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL inc_grant src=%0d addr=%0d: got no grant, required grant within 20 cycles", is_tx, a);
        end else begin
            model_inc(a);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] data);
        bit got = 1'b0;
        data = 'x;
        Cpu_rd_req = 1'b1;
        Cpu_rd_addr = a;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (Cpu_rd_ack === 1'b1) begin
                got = 1'b1;
                data = Cpu_rd_data;
            end
            tick();
        end
        Cpu_rd_req = 1'b0;
        #1;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL cpu_ack addr=%0d: got no ack, required ack within 20 cycles", a);
        end else if (Cpu_rd_ack !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_ack_width addr=%0d: ack=%b one cycle later, required 0", a, Cpu_rd_ack);
        end
    endtask

    task automatic read_and_compare(input logic [AW-1:0] a, input string tag);
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        do_read(a, got);
        want = model_read(a);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s addr=%0d: read 0x%08h, required 0x%08h", tag, a, got, want);
        end
    endtask

    task automatic check_init_sweep(input bit with_reqs);
        if (with_reqs) begin
            Rx_inc_req = 1'b1; Rx_inc_addr = 4'd9;
            Cpu_rd_req = 1'b1; Cpu_rd_addr = 4'd9;
        end
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            n_cmp++;
            if (Init_busy !== 1'b1 || ram_wren !== 1'b1 || ram_addr !== AW'(k) || ram_wdata !== '0) begin
                n_err++;
                $display("FAIL init_cycle %0d: busy=%b wren=%b addr=%0d wdata=0x%08h, required busy=1 wren=1 addr=%0d wdata=0",
                         k, Init_busy, ram_wren, ram_addr, ram_wdata, k);
            end
            if (with_reqs) begin
                n_cmp++;
                if (Rx_inc_gnt !== 1'b0 || Tx_inc_gnt !== 1'b0 || Cpu_rd_ack !== 1'b0) begin
                    n_err++;
                    $display("FAIL init_no_service %0d: rx_gnt=%b tx_gnt=%b ack=%b, required all 0",
                             k, Rx_inc_gnt, Tx_inc_gnt, Cpu_rd_ack);
                end
                if (k == DEPTH - 1) begin
                    Rx_inc_req = 1'b0;
                    Cpu_rd_req = 1'b0;
                end
            end
            tick();
        end
        #1;
        n_cmp++;
        if (Init_busy !== 1'b0) begin
            n_err++;
            $display("FAIL init_done: Init_busy=%b, required 0", Init_busy);
        end
        for (int a = 0; a < DEPTH; a++) exp_cnt[a] = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) tick();
        #1;
        n_cmp++;
        if (Init_busy !== 1'b1 || ram_wren !== 1'b0 || Cpu_rd_ack !== 1'b0 || Cpu_rd_data !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b wren=%b ack=%b data=0x%08h, required busy=1 wren=0 ack=0 data=0",
                     Init_busy, ram_wren, Cpu_rd_ack, Cpu_rd_data);
        end
        tick();
        Reset = 1'b0;
        model_last_tx = 1'b1;
        check_init_sweep(1'b0);
    endtask

    task automatic test_rx_repeat();
        int gcyc [3];
        int cnt = 0;
        tick();
        Rx_inc_req = 1'b1;
        Rx_inc_addr = 4'd3;
        for (int c = 0; c < 15 && cnt < 3; c++) begin
            #1;
            if (Rx_inc_gnt === 1'b1) begin
                gcyc[cnt] = c;
                cnt++;
            end
            tick();
        end
        Rx_inc_req = 1'b0;
        n_cmp++;
        if (cnt != 3) begin
            n_err++;
            $display("FAIL rx_repeat_count: %0d grants, required 3", cnt);
        end else begin
            n_cmp++;
            if (gcyc[1] - gcyc[0] != 3 || gcyc[2] - gcyc[1] != 3) begin
                n_err++;
                $display("FAIL rx_repeat_spacing: gaps %0d,%0d cycles, required 3,3",
                         gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]);
            end
        end
        for (int i = 0; i < cnt; i++) model_inc(4'd3);
        read_and_compare(4'd3, "rx_repeat_read");
    endtask

    task automatic test_round_robin();
        bit gq [$];
        bit want;
        Rx_inc_req = 1'b1; Rx_inc_addr = 4'd1;
        Tx_inc_req = 1'b1; Tx_inc_addr = 4'd2;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (Rx_inc_gnt === 1'b1 && Tx_inc_gnt === 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL rr_double_grant cycle %0d: rx_gnt=1 tx_gnt=1, required one", c);
            end
            if (Rx_inc_gnt === 1'b1) gq.push_back(1'b0);
            if (Tx_inc_gnt === 1'b1) gq.push_back(1'b1);
            tick();
        end
        Rx_inc_req = 1'b0;
        Tx_inc_req = 1'b0;
        n_cmp++;
        if (gq.size() != 4) begin
            n_err++;
            $display("FAIL rr_count: %0d grants, required 4", gq.size());
        end
        foreach (gq[i]) begin
            want = !model_last_tx;
            model_last_tx = want;
            n_cmp++;
            if (gq[i] !== want) begin
                n_err++;
                $display("FAIL rr_order grant %0d: src=%0d, required src=%0d (0=RX 1=TX)", i, gq[i], want);
            end
            model_inc(gq[i] ? 4'd2 : 4'd1);
        end
        read_and_compare(4'd1, "rr_read_rx");
        read_and_compare(4'd2, "rr_read_tx");
    endtask

    task automatic test_saturation();
        pl_en = 1'b1; pl_addr = 4'd5; pl_data = 32'hFFFF_FFFE;
        tick();
        pl_en = 1'b0;
        exp_cnt[5] = 32'hFFFF_FFFE;
        do_inc(1'b0, 4'd5);
        do_inc(1'b1, 4'd5);
        repeat (2) tick();
        n_cmp++;
        if (mem[5] !== exp_cnt[5]) begin
            n_err++;
            $display("FAIL sat_reach: ram[5]=0x%08h, required 0x%08h", mem[5], exp_cnt[5]);
        end
        do_inc(1'b0, 4'd5);
        read_and_compare(4'd5, "sat_hold");
    endtask

    task automatic test_cpu_priority();
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] want;
        int ack_c = -1;
        int gnt_c = -1;
        int want_gnt_c;
`ifdef STAT_CLEAR_ON_READ_EN
        want_gnt_c = 3;
`else
        want_gnt_c = 2;
`endif
        do_inc(1'b0, 4'd3);
        do_inc(1'b1, 4'd3);
        repeat (2) tick();
        want = model_read(4'd3);
        rd1 = 'x;
        Cpu_rd_req = 1'b1; Cpu_rd_addr = 4'd3;
        Rx_inc_req = 1'b1; Rx_inc_addr = 4'd4;
        for (int c = 0; c < 10 && (ack_c < 0 || gnt_c < 0); c++) begin
            #1;
            if (Cpu_rd_ack === 1'b1 && ack_c < 0) begin
                ack_c = c;
                rd1 = Cpu_rd_data;
            end
            if (Rx_inc_gnt === 1'b1 && gnt_c < 0) gnt_c = c;
            tick();
            if (ack_c >= 0) Cpu_rd_req = 1'b0;
            if (gnt_c >= 0) Rx_inc_req = 1'b0;
        end
        Cpu_rd_req = 1'b0;
        Rx_inc_req = 1'b0;
        n_cmp++;
        if (ack_c != 2) begin
            n_err++;
            $display("FAIL prio_ack_cycle: ack at cycle %0d, required 2", ack_c);
        end
        n_cmp++;
        if (gnt_c != want_gnt_c) begin
            n_err++;
            $display("FAIL prio_rx_gnt_cycle: grant at cycle %0d, required %0d", gnt_c, want_gnt_c);
        end
        n_cmp++;
        if (rd1 !== want) begin
            n_err++;
            $display("FAIL prio_read: read 0x%08h, required 0x%08h", rd1, want);
        end
        if (gnt_c >= 0) model_inc(4'd4);
        do_read(4'd3, rd2);
        void'(model_read(4'd3));
`ifdef STAT_CLEAR_ON_READ_EN
        want = '0;
`else
        want = rd1;
`endif
        n_cmp++;
        if (rd2 !== want) begin
            n_err++;
            $display("FAIL reread: read 0x%08h, required 0x%08h", rd2, want);
        end
        read_and_compare(4'd4, "prio_rx_result");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            int op;
            a = AW'($urandom_range(0, DEPTH - 1));
            op = int'($urandom_range(0, 2));
            if (op == 2) read_and_compare(a, "random_read");
            else do_inc(op == 1, a);
        end
        for (int a = 0; a < DEPTH; a++) read_and_compare(AW'(a), "random_final");
    endtask

    task automatic test_reset_mid_op();
        bit got = 1'b0;
        Rx_inc_req = 1'b1; Rx_inc_addr = 4'd7;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (Rx_inc_gnt === 1'b1) got = 1'b1;
            tick();
        end
        Rx_inc_req = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (!got || ram_wren !== 1'b1 || ram_addr !== 4'd7) begin
            n_err++;
            $display("FAIL pre_reset_inc_wr: granted=%b wren=%b addr=%0d, required granted=1 wren=1 addr=7",
                     got, ram_wren, ram_addr);
        end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (ram_wren !== 1'b0 || Init_busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_abort: wren=%b busy=%b, required wren=0 busy=1", ram_wren, Init_busy);
        end
        repeat (2) tick();
        Reset = 1'b0;
        model_last_tx = 1'b1;
        check_init_sweep(1'b1);
        for (int a = 0; a < DEPTH; a++) read_and_compare(AW'(a), "post_reset_zero");
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) exp_cnt[a] = '0;
        test_reset();
        test_rx_repeat();
        test_round_robin();
        test_saturation();
        test_cpu_priority();
        test_random();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
